// File: rtl/clk_switch_ctrl_pkg.sv
// ============================================================================
// clk_switch_pkg : shared types and defaults for the clk0/clk1 switch sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package clk_switch_pkg;

   localparam int DEFAULT_GUARD_CYCLES   = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   typedef enum logic [2:0] {
      C0_ON       = 3'd0,
      C0_OFF_WAIT = 3'd1,
      C1_ON_WAIT  = 3'd2,
      C1_ON       = 3'd3,
      C1_OFF_WAIT = 3'd4,
      C0_ON_WAIT  = 3'd5
   } ctrl_state_e;

   // Counter must hold the larger of the two reload values.
   function automatic int cnt_width(input int guard, input int timeout);
      return (guard > timeout) ? $clog2(guard + 1) : $clog2(timeout + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/clk_switch_ctrl_if.sv
// ============================================================================
// clk_switch_ctrl_if : request handshake and switch-enable bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface clk_switch_ctrl_if;

   logic sw_req;
   logic sw_sel;
   logic sw_ready;
   logic sw_done;
   logic sw_err;
   logic cur_sel;
   logic clk0_enable;
   logic clk1_enable;
   logic clk1_active_async;

   modport master (
      output sw_req, sw_sel, clk1_active_async,
      input  sw_ready, sw_done, sw_err, cur_sel, clk0_enable, clk1_enable
   );

   modport slave (
      input  sw_req, sw_sel, clk1_active_async,
      output sw_ready, sw_done, sw_err, cur_sel, clk0_enable, clk1_enable
   );

endinterface

`default_nettype wire

// File: rtl/clk_sync_2ff.sv
// ============================================================================
// clk_sync_2ff : generic two-flop synchronizer, async active-low reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
// ============================================================================
// clk_switch_ctrl : break-before-make sequencer for the AXI/pixel clock switch
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_switch_ctrl
   import clk_switch_pkg::*;
#(
   parameter int GUARD_CYCLES   = DEFAULT_GUARD_CYCLES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic             clk0,
   input  logic             clk0_rst_n,
   clk_switch_ctrl_if.slave bus
);

   localparam int            CW           = cnt_width(GUARD_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0] GUARD_INIT   = CW'(GUARD_CYCLES);
   localparam logic [CW-1:0] TIMEOUT_INIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   ctrl_state_e   state_q;
   logic [CW-1:0] cnt_q;
   logic          clk0_en_q;
   logic          clk1_en_q;
   logic          cur_sel_q;
   logic          sw_ready_q;
   logic          sw_done_q;
   logic          sw_err_q;
   logic          act_s;

   clk_sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
   ) u_act_sync (
      .clk_i  (clk0),
      .rst_ni (clk0_rst_n),
      .d_i    (bus.clk1_active_async),
      .q_o    (act_s)
   );

   always_ff @(posedge clk0 or negedge clk0_rst_n) begin
      if (!clk0_rst_n) begin
         state_q    <= C0_ON;
         cnt_q      <= '0;
         clk0_en_q  <= 1'b1;
         clk1_en_q  <= 1'b0;
         cur_sel_q  <= 1'b0;
         sw_ready_q <= 1'b1;
         sw_done_q  <= 1'b0;
         sw_err_q   <= 1'b0;
      end else begin
         sw_done_q <= 1'b0;
         sw_err_q  <= 1'b0;
         case (state_q)
            C0_ON: begin
               if (bus.sw_req) begin
                  if (bus.sw_sel) begin
                     clk0_en_q  <= 1'b0;
                     cnt_q      <= GUARD_INIT;
                     sw_ready_q <= 1'b0;
                     state_q    <= C0_OFF_WAIT;
                  end else begin
                     sw_done_q <= 1'b1;
                  end
               end
            end
            C0_OFF_WAIT: begin
               if (cnt_q == CNT_ONE) begin
                  clk1_en_q <= 1'b1;
                  cnt_q     <= TIMEOUT_INIT;
                  state_q   <= C1_ON_WAIT;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            C1_ON_WAIT: begin
               if (act_s) begin
                  cur_sel_q  <= 1'b1;
                  sw_done_q  <= 1'b1;
                  sw_ready_q <= 1'b1;
                  state_q    <= C1_ON;
               end else if (cnt_q == CNT_ONE) begin
                  // Pixel clock never came up: fall back to the AXI clock.
                  clk1_en_q  <= 1'b0;
                  clk0_en_q  <= 1'b1;
                  sw_err_q   <= 1'b1;
                  sw_ready_q <= 1'b1;
                  state_q    <= C0_ON;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            C1_ON: begin
               if (bus.sw_req) begin
                  if (!bus.sw_sel) begin
                     clk1_en_q  <= 1'b0;
                     cnt_q      <= TIMEOUT_INIT;
                     sw_ready_q <= 1'b0;
                     state_q    <= C1_OFF_WAIT;
                  end else begin
                     sw_done_q <= 1'b1;
                  end
               end
            end
            C1_OFF_WAIT: begin
               // A gate that never reports off still proceeds, flagged as an error.
               if (!act_s || (cnt_q == CNT_ONE)) begin
                  clk0_en_q <= 1'b1;
                  cnt_q     <= GUARD_INIT;
                  sw_err_q  <= act_s;
                  state_q   <= C0_ON_WAIT;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            C0_ON_WAIT: begin
               if (cnt_q == CNT_ONE) begin
                  cur_sel_q  <= 1'b0;
                  sw_done_q  <= 1'b1;
                  sw_ready_q <= 1'b1;
                  state_q    <= C0_ON;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_q    <= C0_ON;
               clk0_en_q  <= 1'b1;
               clk1_en_q  <= 1'b0;
               cur_sel_q  <= 1'b0;
               sw_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.clk0_enable = clk0_en_q;
   assign bus.clk1_enable = clk1_en_q;
   assign bus.cur_sel     = cur_sel_q;
   assign bus.sw_ready    = sw_ready_q;
   assign bus.sw_done     = sw_done_q;
   assign bus.sw_err      = sw_err_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
// ============================================================================
// tb_clk_switch_ctrl : directed self-checking bench for clk_switch_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clk_switch_ctrl;

   localparam int GUARD = 8;
   localparam int TMO   = 16;

   logic clk0;
   logic clk0_rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   base;
   bit   both_seen = 1'b0;
   bit   excl_bad  = 1'b0;

   clk_switch_ctrl_if bus ();

   clk_switch_ctrl #(
      .GUARD_CYCLES   (GUARD),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk0       (clk0),
      .clk0_rst_n (clk0_rst_n),
      .bus        (bus)
   );

   initial begin
      clk0 = 1'b0;
      forever #5 clk0 = ~clk0;
   end

   // Pulse counting and invariant watch, sampled mid-cycle.
   always @(negedge clk0) begin
      if (bus.sw_done) done_cnt++;
      if (bus.clk0_enable && bus.clk1_enable) both_seen = 1'b1;
      if (bus.sw_done && bus.sw_err) excl_bad = 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      bus.sw_req            = 1'b0;
      bus.sw_sel            = 1'b0;
      bus.clk1_active_async = 1'b0;
      clk0_rst_n            = 1'b0;

      // Reset state
      step(5);
      chk("rst_clk0_en", bus.clk0_enable, 1);
      chk("rst_clk1_en", bus.clk1_enable, 0);
      chk("rst_cur_sel", bus.cur_sel, 0);
      chk("rst_ready", bus.sw_ready, 1);
      chk("rst_done", bus.sw_done, 0);
      chk("rst_err", bus.sw_err, 0);
      #3 clk0_rst_n = 1'b1;
      step(2);
      chk("post_rst_ready", bus.sw_ready, 1);
      chk("post_rst_clk0_en", bus.clk0_enable, 1);

      // Same-source request in C0_ON
      base = done_cnt;
      bus.sw_req = 1'b1; bus.sw_sel = 1'b0;
      tick();
      bus.sw_req = 1'b0;
      chk("same0_done", bus.sw_done, 1);
      chk("same0_ready", bus.sw_ready, 1);
      chk("same0_clk0_en", bus.clk0_enable, 1);
      chk("same0_clk1_en", bus.clk1_enable, 0);
      tick();
      chk("same0_done_pulse", bus.sw_done, 0);
      chk("same0_done_count", done_cnt - base, 1);

      // clk0 -> clk1
      base = done_cnt;
      bus.sw_req = 1'b1; bus.sw_sel = 1'b1;
      tick();
      bus.sw_req = 1'b0;
      chk("c01_clk0_fall", bus.clk0_enable, 0);
      chk("c01_clk1_still_off", bus.clk1_enable, 0);
      chk("c01_busy", bus.sw_ready, 0);
      step(GUARD - 1);
      chk("c01_clk1_before_guard", bus.clk1_enable, 0);
      tick();
      chk("c01_clk1_rise", bus.clk1_enable, 1);
      chk("c01_clk0_off", bus.clk0_enable, 0);
      step(3);
      bus.clk1_active_async = 1'b1;
      step(2);
      chk("c01_done_early", bus.sw_done, 0);
      chk("c01_sel_early", bus.cur_sel, 0);
      tick();
      chk("c01_done", bus.sw_done, 1);
      chk("c01_cur_sel", bus.cur_sel, 1);
      chk("c01_ready", bus.sw_ready, 1);
      tick();
      chk("c01_done_pulse", bus.sw_done, 0);
      chk("c01_done_count", done_cnt - base, 1);

      // clk1 -> clk0
      base = done_cnt;
      bus.sw_req = 1'b1; bus.sw_sel = 1'b0;
      tick();
      bus.sw_req = 1'b0;
      chk("c10_clk1_fall", bus.clk1_enable, 0);
      chk("c10_clk0_off", bus.clk0_enable, 0);
      chk("c10_busy", bus.sw_ready, 0);
      step(3);
      bus.clk1_active_async = 1'b0;
      step(2);
      chk("c10_clk0_before_sync", bus.clk0_enable, 0);
      tick();
      chk("c10_clk0_rise", bus.clk0_enable, 1);
      chk("c10_clk1_off", bus.clk1_enable, 0);
      chk("c10_sel_held", bus.cur_sel, 1);
      chk("c10_no_err", bus.sw_err, 0);
      step(GUARD - 1);
      chk("c10_done_early", bus.sw_done, 0);
      tick();
      chk("c10_done", bus.sw_done, 1);
      chk("c10_cur_sel", bus.cur_sel, 0);
      chk("c10_ready", bus.sw_ready, 1);
      tick();
      chk("c10_done_count", done_cnt - base, 1);

      // Timeout with clk1 gate never reporting active
      base = done_cnt;
      bus.sw_req = 1'b1; bus.sw_sel = 1'b1;
      tick();
      bus.sw_req = 1'b0;
      step(GUARD);
      chk("tmo_clk1_rise", bus.clk1_enable, 1);
      step(TMO - 1);
      chk("tmo_err_early", bus.sw_err, 0);
      chk("tmo_clk1_still_on", bus.clk1_enable, 1);
      tick();
      chk("tmo_err", bus.sw_err, 1);
      chk("tmo_clk0_en", bus.clk0_enable, 1);
      chk("tmo_clk1_en", bus.clk1_enable, 0);
      chk("tmo_cur_sel", bus.cur_sel, 0);
      chk("tmo_no_done", bus.sw_done, 0);
      chk("tmo_ready", bus.sw_ready, 1);
      tick();
      chk("tmo_err_pulse", bus.sw_err, 0);
      chk("tmo_done_count", done_cnt - base, 0);

      // Request while busy is ignored
      base = done_cnt;
      bus.sw_req = 1'b1; bus.sw_sel = 1'b1;
      tick();
      bus.sw_req = 1'b0;
      step(2);
      bus.sw_req = 1'b1; bus.sw_sel = 1'b0;
      tick();
      bus.sw_req = 1'b0;
      chk("busy_clk0_en", bus.clk0_enable, 0);
      chk("busy_ready", bus.sw_ready, 0);
      chk("busy_no_done", bus.sw_done, 0);
      step(GUARD - 3);
      chk("busy_clk1_rise", bus.clk1_enable, 1);
      bus.clk1_active_async = 1'b1;
      step(4);
      chk("busy_cur_sel", bus.cur_sel, 1);
      chk("busy_ready_after", bus.sw_ready, 1);
      chk("busy_done_count", done_cnt - base, 1);

      // Same-source request in C1_ON
      bus.sw_req = 1'b1; bus.sw_sel = 1'b1;
      tick();
      bus.sw_req = 1'b0;
      chk("same1_done", bus.sw_done, 1);
      chk("same1_clk1_en", bus.clk1_enable, 1);
      chk("same1_clk0_en", bus.clk0_enable, 0);
      chk("same1_ready", bus.sw_ready, 1);

      // Back to clk0, then reset in the middle of C1_ON_WAIT
      bus.clk1_active_async = 1'b0;
      bus.sw_req = 1'b1; bus.sw_sel = 1'b0;
      tick();
      bus.sw_req = 1'b0;
      step(20);
      chk("pre_mid_cur_sel", bus.cur_sel, 0);
      chk("pre_mid_clk0_en", bus.clk0_enable, 1);
      bus.sw_req = 1'b1; bus.sw_sel = 1'b1;
      tick();
      bus.sw_req = 1'b0;
      step(GUARD + 3);
      chk("mid_clk1_on", bus.clk1_enable, 1);
      #2 clk0_rst_n = 1'b0;
      #1;
      chk("mid_rst_clk1_en", bus.clk1_enable, 0);
      chk("mid_rst_clk0_en", bus.clk0_enable, 1);
      chk("mid_rst_cur_sel", bus.cur_sel, 0);
      chk("mid_rst_ready", bus.sw_ready, 1);
      chk("mid_rst_err", bus.sw_err, 0);
      step(2);
      #3 clk0_rst_n = 1'b1;
      tick();

      // Fresh switch after reset
      base = done_cnt;
      bus.sw_req = 1'b1; bus.sw_sel = 1'b1;
      tick();
      bus.sw_req = 1'b0;
      step(GUARD);
      chk("fresh_clk1_rise", bus.clk1_enable, 1);
      bus.clk1_active_async = 1'b1;
      step(3);
      chk("fresh_done", bus.sw_done, 1);
      chk("fresh_cur_sel", bus.cur_sel, 1);
      tick();
      chk("fresh_done_count", done_cnt - base, 1);

      chk("enables_never_both", both_seen, 0);
      chk("done_err_exclusive", excl_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
